// File: rtl/nvram_upload_spi.sv
// NVRAM upload over the host SPI link: a BEGIN/DATA/END command frame protocol that
// streams core bytes out on SPI_DO, using a prefetch buffer to hide the core read latency.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | no frame; waits for SS2 low (only after SS2 has been seen high)
// ST_CMD    | shifting in the command byte
// ST_BEGIN  | BEGIN accepted; remaining bytes of the frame ignored
// ST_DATA   | shifting prefetched bytes out on SPI_DO, one per byte slot
// ST_END    | END accepted; remaining bytes of the frame ignored
// ST_IGNORE | unknown command; waits for SS2 high
module nvram_upload_spi #(
  parameter int RD_LAT = 4,
  parameter int ADDR_W = 25
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              SPI_SCK,
  input  logic              SPI_SS2,
  input  logic              SPI_DI,
  output logic              SPI_DO,
  output logic              spi_do_oe,
  output logic              ioctl_upload,
  output logic [ADDR_W-1:0] ioctl_addr,
  input  logic [7:0]        ioctl_din,
  output logic              ioctl_rd
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_BEGIN, ST_DATA, ST_END, ST_IGNORE
  } state_t;

  localparam logic [3:0] RD_LAT_C = 4'(RD_LAT);

  state_t      state_q, state_d;
  logic [1:0]  sck_s, ss_s, di_s, fill;
  logic        sck_q, armed;
  logic [2:0]  bit_cnt;
  logic [6:0]  rx_sr;
  logic [7:0]  rx_byte, do_sr, pf_buf;
  logic [3:0]  pf_cnt;
  logic        pf_busy;
  logic        ss, sck_rise, sck_fall, byte_done;
  logic        cmd_begin, cmd_end, do_load;

  assign ss        = ss_s[1];
  assign sck_rise  = sck_s[1] & ~sck_q;
  assign sck_fall  = ~sck_s[1] & sck_q;
  assign byte_done = sck_rise && (bit_cnt == 3'd7);
  assign rx_byte   = {rx_sr, di_s[1]};
  assign spi_do_oe = !ss && (state_q == ST_DATA);
  assign SPI_DO    = spi_do_oe ? do_sr[7] : 1'b1;

  // armed only once the synchronisers hold real samples, so a reset released
  // mid-frame cannot mistake the reset value of SS2 for a deselect
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sck_s <= 2'b11;
      ss_s  <= 2'b11;
      di_s  <= 2'b00;
      sck_q <= 1'b1;
      fill  <= 2'b00;
      armed <= 1'b0;
    end else begin
      sck_s <= {sck_s[0], SPI_SCK};
      ss_s  <= {ss_s[0], SPI_SS2};
      di_s  <= {di_s[0], SPI_DI};
      sck_q <= sck_s[1];
      fill  <= {fill[0], 1'b1};
      if (fill[1] && ss) armed <= 1'b1;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cmd_begin = 1'b0;
    cmd_end   = 1'b0;
    do_load   = 1'b0;
    if (ss) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (armed) state_d = ST_CMD;
        ST_CMD: begin
          if (byte_done) begin
            case (rx_byte)
              8'h5A: begin state_d = ST_BEGIN; cmd_begin = 1'b1; end
              8'h5B: begin state_d = ST_DATA;  do_load   = 1'b1; end
              8'h5C: begin state_d = ST_END;   cmd_end   = 1'b1; end
              default: state_d = ST_IGNORE;
            endcase
          end
        end
        ST_DATA: if (byte_done) do_load = 1'b1;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt <= 3'd0;
      rx_sr   <= 7'd0;
    end else if (ss || state_q == ST_IDLE) begin
      bit_cnt <= 3'd0;
      rx_sr   <= 7'd0;
    end else if (sck_rise) begin
      bit_cnt <= bit_cnt + 3'd1;
      rx_sr   <= rx_byte[6:0];
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ioctl_upload <= 1'b0;
      ioctl_addr   <= '0;
    end else if (cmd_begin) begin
      ioctl_upload <= 1'b1;
      ioctl_addr   <= '0;
    end else if (cmd_end) begin
      ioctl_upload <= 1'b0;
    end else if (do_load) begin
      ioctl_addr <= ioctl_addr + ADDR_W'(1);
    end
  end

  // a new address restarts the latency countdown; ioctl_din is taken when it expires
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      pf_busy  <= 1'b0;
      pf_cnt   <= 4'd0;
      pf_buf   <= 8'hFF;
      ioctl_rd <= 1'b0;
    end else begin
      ioctl_rd <= 1'b0;
      if (cmd_begin || do_load) begin
        pf_busy <= 1'b1;
        pf_cnt  <= RD_LAT_C;
      end else if (pf_busy) begin
        if (pf_cnt == 4'd0) begin
          pf_buf   <= ioctl_din;
          ioctl_rd <= 1'b1;
          pf_busy  <= 1'b0;
        end else begin
          pf_cnt <= pf_cnt - 4'd1;
        end
      end
    end
  end

  // falls are ignored until the first rise of a slot so the freshly loaded MSB survives
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      do_sr <= 8'hFF;
    end else if (do_load) begin
      do_sr <= pf_buf;
    end else if (state_q == ST_DATA && !ss && sck_fall && bit_cnt != 3'd0) begin
      do_sr <= {do_sr[6:0], 1'b1};
    end
  end

endmodule

// File: tb/tb_nvram_upload_spi.sv
// Directed bench for nvram_upload_spi: drives host SPI frames and models a core whose
// byte[n] = n ^ 0xA5 appears RD_LAT cycles after the address changes.
module tb_nvram_upload_spi;

  localparam int RD_LAT = 4;
  localparam int ADDR_W = 25;
  localparam int HALF   = 8;

  logic              clk_sys = 1'b0;
  logic              reset_n;
  logic              SPI_SCK, SPI_SS2, SPI_DI;
  logic              SPI_DO, spi_do_oe, ioctl_upload, ioctl_rd;
  logic [ADDR_W-1:0] ioctl_addr;
  logic [7:0]        ioctl_din;

  int checks = 0, failures = 0;
  int cyc = 0, up_rise = -1, up_fall = -1, rd_t = -1, rd_cnt = 0, oe_cnt = 0;
  int last_rise = 0, snap_rd, snap_oe;
  logic              up_prev = 1'b0;
  logic [ADDR_W-1:0] snap_addr;
  logic [7:0]        r, ra, rb;
  logic [ADDR_W-1:0] pipe [RD_LAT] = '{default: '0};

  nvram_upload_spi #(.RD_LAT(RD_LAT), .ADDR_W(ADDR_W)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .SPI_SCK(SPI_SCK), .SPI_SS2(SPI_SS2),
    .SPI_DI(SPI_DI), .SPI_DO(SPI_DO), .spi_do_oe(spi_do_oe), .ioctl_upload(ioctl_upload),
    .ioctl_addr(ioctl_addr), .ioctl_din(ioctl_din), .ioctl_rd(ioctl_rd)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) begin
    pipe[0] <= ioctl_addr;
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign ioctl_din = pipe[RD_LAT-1][7:0] ^ 8'hA5;

  always @(posedge clk_sys) begin
    #1;
    cyc = cyc + 1;
    if (ioctl_upload && !up_prev) up_rise = cyc;
    if (!ioctl_upload && up_prev) up_fall = cyc;
    up_prev = ioctl_upload;
    if (ioctl_rd) begin rd_t = cyc; rd_cnt = rd_cnt + 1; end
    if (spi_do_oe) oe_cnt = oe_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      failures = failures + 1;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < n; i++) begin
      SPI_DI = tx[7-i];
      tick(HALF);
      rx = {rx[6:0], SPI_DO};
      SPI_SCK = 1'b1;
      last_rise = cyc;
      tick(HALF);
      SPI_SCK = 1'b0;
    end
  endtask

  task automatic ss_low();
    SPI_SS2 = 1'b0;
    tick(HALF);
  endtask

  task automatic ss_high();
    tick(HALF);
    SPI_SS2 = 1'b1;
    tick(HALF);
  endtask

  initial begin
    reset_n = 1'b0; SPI_SS2 = 1'b1; SPI_SCK = 1'b0; SPI_DI = 1'b0;
    tick(3);
    chk("rst_upload", 32'(ioctl_upload), 32'd0);
    chk("rst_addr",   32'(ioctl_addr),   32'd0);
    chk("rst_do",     32'(SPI_DO),       32'd1);
    chk("rst_oe",     32'(spi_do_oe),    32'd0);
    chk("rst_rd",     32'(ioctl_rd),     32'd0);
    reset_n = 1'b1;
    tick(5);

    // BEGIN: upload, address 0, prefetch RD_LAT+1 cycles later
    snap_rd = rd_cnt;
    ss_low(); spi_bits(8'h5A, 8, r); ss_high();
    chk("begin_upload", 32'(ioctl_upload), 32'd1);
    chk("begin_addr",   32'(ioctl_addr),   32'd0);
    chk("begin_rd_lat", 32'(rd_t - up_rise), 32'(RD_LAT + 1));
    chk("begin_rd_cnt", 32'(rd_cnt - snap_rd), 32'd1);

    // DATA frame reads byte0..byte2
    ss_low(); spi_bits(8'h5B, 8, r);
    spi_bits(8'h00, 8, r);  chk("data_b0", 32'(r), 32'hA5);
    spi_bits(8'h00, 8, r);  chk("data_b1", 32'(r), 32'hA4);
    chk("data_oe", 32'(spi_do_oe), 32'd1);
    spi_bits(8'h00, 7, ra);
    chk("data_addr", 32'(ioctl_addr), 32'd3);
    spi_bits(8'h00, 1, rb);
    chk("data_b2", 32'({ra[6:0], rb[0]}), 32'hA7);
    ss_high();
    chk("data_oe_off", 32'(spi_do_oe), 32'd0);

    // abort mid-byte, next frame continues with byte2
    ss_low(); spi_bits(8'h5A, 8, r); ss_high();
    ss_low(); spi_bits(8'h5B, 8, r);
    spi_bits(8'h00, 8, r);  chk("abort_b0", 32'(r), 32'hA5);
    spi_bits(8'h00, 4, r);
    ss_high();
    chk("abort_addr", 32'(ioctl_addr), 32'd2);
    ss_low(); spi_bits(8'h5B, 8, r);
    spi_bits(8'h00, 7, ra);
    chk("resume_addr", 32'(ioctl_addr), 32'd3);
    spi_bits(8'h00, 1, rb);
    chk("resume_b2", 32'({ra[6:0], rb[0]}), 32'hA7);
    ss_high();

    // END: upload drops one cycle after the detected 8th rise (2 sync + 1)
    snap_oe = oe_cnt;
    ss_low(); spi_bits(8'h5C, 8, r); ss_high();
    chk("end_fall_lat", 32'(up_fall - last_rise), 32'd3);
    chk("end_upload",   32'(ioctl_upload), 32'd0);
    chk("end_oe",       32'(oe_cnt - snap_oe), 32'd0);

    // unknown command swallows the rest of the frame
    snap_addr = ioctl_addr; snap_rd = rd_cnt; snap_oe = oe_cnt;
    ss_low(); spi_bits(8'h33, 8, r); spi_bits(8'h5A, 8, r); ss_high();
    chk("ign_upload", 32'(ioctl_upload), 32'd0);
    chk("ign_addr",   32'(ioctl_addr),   32'(snap_addr));
    chk("ign_rd",     32'(rd_cnt - snap_rd), 32'd0);
    chk("ign_oe",     32'(oe_cnt - snap_oe), 32'd0);

    // asynchronous reset mid-DATA byte
    ss_low(); spi_bits(8'h5A, 8, r); ss_high();
    ss_low(); spi_bits(8'h5B, 8, r); spi_bits(8'h00, 4, r);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_upload", 32'(ioctl_upload), 32'd0);
    chk("arst_addr",   32'(ioctl_addr),   32'd0);
    chk("arst_do",     32'(SPI_DO),       32'd1);
    chk("arst_oe",     32'(spi_do_oe),    32'd0);
    chk("arst_rd",     32'(ioctl_rd),     32'd0);
    tick(2);
    reset_n = 1'b1;
    spi_bits(8'h5A, 8, r);
    tick(HALF);
    chk("arst_midframe_idle", 32'(ioctl_upload), 32'd0);
    ss_high();
    snap_rd = rd_cnt;
    ss_low(); spi_bits(8'h5A, 8, r); ss_high();
    chk("arst_begin_upload", 32'(ioctl_upload), 32'd1);
    chk("arst_begin_addr",   32'(ioctl_addr),   32'd0);
    chk("arst_begin_rd_lat", 32'(rd_t - up_rise), 32'(RD_LAT + 1));
    chk("arst_begin_rd_cnt", 32'(rd_cnt - snap_rd), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
